// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests under a
// 3-credit limit, and buffers returned {pc, inst} pairs for the IF/ID register.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  en_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] inst_o
);

  localparam int                    DEPTH    = 3;
  localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            out_cnt_q, out_cnt_d;
  logic [1:0]            drop_cnt_q, drop_cnt_d;
  logic [1:0]            q_cnt_q, q_cnt_d;
  logic [1:0]            pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [1:0]            oq_wr_q, oq_wr_d, oq_rd_q, oq_rd_d;

  logic [DATA_WIDTH-1:0] pend_pc_q [DEPTH];
  logic [DATA_WIDTH-1:0] oq_pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0] oq_inst_q [DEPTH];

  logic rsp, drop, gnt, push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    // NOTE: every signal driven in this block gets a value on every path, so no latches are inferred.
    rsp         = imem_rvalid_i && (out_cnt_q != 2'd0);
    drop        = rsp && (drop_cnt_q != 2'd0);
    // Outstanding requests plus buffered entries never exceed the queue depth.
    imem_req_o  = !rst_i && !redirect_i && ((3'(out_cnt_q) + 3'(q_cnt_q)) < 3'd3);
    imem_addr_o = pc_q;
    gnt         = imem_req_o && imem_gnt_i;
    valid_o     = (q_cnt_q != 2'd0);
    push        = rsp && !drop && !redirect_i;
    pop         = valid_o && en_i && !redirect_i;
    pc_o        = valid_o ? oq_pc_q[oq_rd_q]   : '0;
    inst_o      = valid_o ? oq_inst_q[oq_rd_q] : NOP_INST;

    pc_d        = pc_q;
    if (redirect_i)
      pc_d = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    else if (gnt)
      pc_d = pc_q + DATA_WIDTH'(4);

    out_cnt_d   = out_cnt_q + 2'(gnt) - 2'(rsp);
    // A redirect condemns every request still in flight after this cycle.
    drop_cnt_d  = redirect_i ? (out_cnt_q - 2'(rsp)) : (drop_cnt_q - 2'(drop));
    pend_wr_d   = gnt ? ptr_inc(pend_wr_q) : pend_wr_q;
    pend_rd_d   = rsp ? ptr_inc(pend_rd_q) : pend_rd_q;

    oq_wr_d     = push ? ptr_inc(oq_wr_q) : oq_wr_q;
    oq_rd_d     = pop  ? ptr_inc(oq_rd_q) : oq_rd_q;
    q_cnt_d     = q_cnt_q + 2'(push) - 2'(pop);
    if (redirect_i) begin
      oq_wr_d = 2'd0;
      oq_rd_d = 2'd0;
      q_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= 2'd0;
      drop_cnt_q <= 2'd0;
      q_cnt_q    <= 2'd0;
      pend_wr_q  <= 2'd0;
      pend_rd_q  <= 2'd0;
      oq_wr_q    <= 2'd0;
      oq_rd_q    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      q_cnt_q    <= q_cnt_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      oq_wr_q    <= oq_wr_d;
      oq_rd_q    <= oq_rd_d;
    end
  end

  // NOTE: storage arrays are not reset; the pointers and counts alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (gnt)
      pend_pc_q[pend_wr_q] <= pc_q;
    if (push) begin
      oq_pc_q[oq_wr_q]   <= pend_pc_q[pend_rd_q];
      oq_inst_q[oq_wr_q] <= imem_rdata_i;
    end
  end

  rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) !(imem_rvalid_i && (out_cnt_q == 2'd0))
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model, expected-stream
// scoreboard and a separate output monitor, plus directed scenarios.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, gnt, rvalid, redir, en;
  logic [31:0] rdata, rpc;
  logic        req, valid;
  logic [31:0] addr, pc, inst;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_inst;

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redir), .redirect_pc_i(rpc), .en_i(en),
    .valid_o(valid), .pc_o(pc), .inst_o(inst)
  );

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(1'b1),
    .imem_rvalid_i(1'b0), .imem_rdata_i(32'h0),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .en_i(1'b0),
    .valid_o(w_valid), .pc_o(w_pc), .inst_o(w_inst)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_t;

  mem_t        mem_q[$];    // granted requests awaiting a memory response
  logic [31:0] sb_q[$];     // pcs IF/ID should still receive, oldest first
  int          cyc, epoch, mq_cnt;
  logic [31:0] model_pc;
  int          n_checks, n_pass;

  int gnt_pct, en_pct, redir_pct, lat_min, lat_max;
  bit redir_when_two, redir_on_rsp, redir_hit;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    gnt    = ($urandom_range(99) < gnt_pct);
    en     = ($urandom_range(99) < en_pct);
    redir  = ($urandom_range(99) < redir_pct);
    rpc    = $urandom();
    rvalid = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rdata  = (mem_q.size() > 0) ? (mem_q[0].addr ^ KEY) : 32'h0;
    if (redir_when_two && mem_q.size() == 2) begin
      redir = 1'b1; rpc = 32'h0000_0103; redir_when_two = 1'b0; redir_hit = 1'b1;
    end
    if (redir_on_rsp && rvalid && valid && mem_q.size() >= 2) begin
      redir = 1'b1; en = 1'b1; redir_on_rsp = 1'b0; redir_hit = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; redir = 1'b0; en = 1'b0;
    mem_q.delete(); sb_q.delete();
    mq_cnt = 0; model_pc = 32'h0; epoch++;
    #1;
    check("reset imem_req_o", req, 1'b0);
    check("reset valid_o", valid, 1'b0);
    check("reset pc_o", pc, 32'h0);
    check("reset inst_o", inst, 32'h13);
    check("reset imem_addr_o", addr, 32'h0);
    check("reset wrap imem_addr_o", w_addr, 32'hFFFF_FFF8);
    check("reset wrap imem_req_o", w_req, 1'b0);
    repeat (2) @(posedge clk);
    step();
    rst = 1'b0;
    #1;
  endtask

  // Reference model: credit, address and occupancy rules; memory side.
  always @(negedge clk) begin : model_blk
    bit   exp_req;
    int   q_before;
    mem_t e;
    if (!rst) begin
      exp_req  = !redir && (mem_q.size() + mq_cnt < 3);
      q_before = mq_cnt;
      check("imem_req_o", req, exp_req);
      check("valid_o", valid, q_before != 0);
      check("imem_addr_o", addr, model_pc);
      if (rvalid && mem_q.size() > 0) begin
        e = mem_q.pop_front();
        if (e.epoch == epoch && !redir) mq_cnt++;
      end
      if (q_before != 0 && en && !redir) mq_cnt--;
      if (req && gnt) begin
        e.addr  = addr;
        e.due   = cyc + int'($urandom_range(lat_max, lat_min));
        e.epoch = epoch;
        mem_q.push_back(e);
        sb_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
      if (redir) begin
        mq_cnt   = 0;
        epoch++;
        model_pc = {rpc[31:2], 2'b00};
        sb_q.delete();
      end
    end
  end

  // Monitor: every accepted head entry must match the next expected pc.
  always @(negedge clk) begin : mon_blk
    logic [31:0] exp_pc;
    if (!rst) begin
      if (valid && en && !redir) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard: pc_o %h delivered with nothing expected (cycle %0d)", pc, cyc);
        end else begin
          exp_pc = sb_q.pop_front();
          check("pc_o", pc, exp_pc);
          check("inst_o", inst, exp_pc ^ KEY);
        end
      end else if (!valid) begin
        check("idle pc_o", pc, 32'h0);
        check("idle inst_o", inst, 32'h13);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int vcount, waited, r_cyc;
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; redir = 1'b0; en = 1'b0;
    rdata = 32'h0; rpc = 32'h0;
    cyc = 0; epoch = 0; mq_cnt = 0; model_pc = 32'h0;
    n_checks = 0; n_pass = 0;
    redir_when_two = 1'b0; redir_on_rsp = 1'b0; redir_hit = 1'b0;

    // Free run with 1-cycle memory; wrap instance fetches alongside.
    gnt_pct = 100; en_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
    do_reset();
    check("wrap addr c0", w_addr, 32'hFFFF_FFF8);
    check("wrap req c0", w_req, 1'b1);
    step();
    check("wrap addr c1", w_addr, 32'hFFFF_FFFC);
    check("valid c1", valid, 1'b0);
    step();
    check("wrap addr c2", w_addr, 32'h0000_0000);
    check("valid c2", valid, 1'b1);
    check("pc c2", pc, 32'h0);
    step();
    check("wrap req c3 credit", w_req, 1'b0);
    check("pc c3", pc, 32'h4);
    step();
    check("pc c4", pc, 32'h8);
    step();
    check("pc c5", pc, 32'hC);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid) vcount++;
    end
    check("throughput valid cycles", vcount, 20);
    check("wrap valid", w_valid, 1'b0);

    // Downstream stall right after reset.
    en_pct = 0;
    do_reset();
    repeat (6) step();
    check("stall granted count", sb_q.size(), 3);
    check("stall req", req, 1'b0);
    check("stall head valid", valid, 1'b1);
    check("stall head pc", pc, 32'h0);
    en_pct = 100;
    repeat (10) step();

    // Redirect while two 3-cycle requests are in flight.
    lat_min = 3; lat_max = 3;
    do_reset();
    redir_hit = 1'b0; redir_when_two = 1'b1;
    waited = 0;
    while (!redir_hit && waited < 20) begin step(); waited++; end
    check("redirect two outstanding issued", redir_hit, 1'b1);
    r_cyc = cyc;
    step();
    check("valid after redirect", valid, 1'b0);
    waited = 0;
    while (!valid && waited < 20) begin step(); waited++; end
    check("first pc after redirect", pc, 32'h100);
    check("redirect to valid latency", cyc - r_cyc, 5);
    repeat (10) step();

    // Redirect coinciding with a response and a head pop.
    en_pct = 50; lat_min = 2; lat_max = 3;
    redir_hit = 1'b0; redir_on_rsp = 1'b1;
    waited = 0;
    while (!redir_hit && waited < 200) begin step(); waited++; end
    check("coincident redirect issued", redir_hit, 1'b1);
    redir_on_rsp = 1'b0;
    step();
    check("queue cleared after coincident redirect", valid, 1'b0);
    repeat (20) step();

    // Grant withheld for four cycles, then resumed.
    gnt_pct = 0; en_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("withheld addr", addr, 32'h0);
      check("withheld req", req, 1'b1);
      step();
    end
    gnt_pct = 100;
    waited = 0;
    while (!valid && waited < 20) begin step(); waited++; end
    check("resume pc", pc, 32'h0);
    repeat (10) step();

    // Random traffic with occasional redirects.
    gnt_pct = 70; en_pct = 70; redir_pct = 4; lat_min = 1; lat_max = 4;
    repeat (3000) step();

    // Second reset mid-operation, then a short clean run.
    gnt_pct = 100; en_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 2;
    do_reset();
    repeat (30) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
